// File: rtl/btn_pkg.sv
// Button conditioner shared types and default timing constants.
// Imported by btn_channel and btn_conditioner.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } e_btn_state;

  // 20 ms debounce, 1 s long press, 250 ms repeat at 50 MHz
  localparam int unsigned BTN_DEBOUNCE_DEF = 1_000_000;
  localparam int unsigned BTN_LONG_DEF     = 50_000_000;
  localparam int unsigned BTN_REPEAT_DEF   = 12_500_000;

endpackage

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, debounce FSM, hold and repeat counters.
// Ports: clk, reset (sync, active-low), btn_n_i (raw, active-low),
//   level_o, press_o, release_o, long_o (all registered).
// Auto-repeat is built only when BTN_REPEAT_EN is defined.
module btn_channel
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_DEF,
  parameter int unsigned REPEAT_CYCLES     = BTN_REPEAT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam logic [31:0] DB = 32'(DEBOUNCE_CYCLES);
  localparam logic [31:0] LP = 32'(LONG_PRESS_CYCLES);

  e_btn_state  state_q;
  logic        sync1_q;
  logic        sync2_q;
  logic [31:0] db_q;
  logic [31:0] hold_q;
  logic        level_q;
  logic        press_q;
  logic        release_q;
  logic        long_q;
  logic        s;
  logic        held;
  logic        rel_acc;
  logic        rep_fire;

  assign s       = ~sync2_q;
  // stable hold with long press already reported
  assign held    = (state_q == PRESSED) && (hold_q == LP);
  assign rel_acc = (state_q == RELEASE_WAIT) && !s && (db_q == DB);

`ifdef BTN_REPEAT_EN
  logic [31:0] rep_q;

  assign rep_fire = held && (rep_q + 32'd1 == 32'(REPEAT_CYCLES));

  always_ff @(posedge clk) begin
    if (!reset) begin
      rep_q <= '0;
    end else if (rel_acc) begin
      rep_q <= '0;
    end else if (held) begin
      rep_q <= rep_fire ? '0 : rep_q + 32'd1;
    end
  end
`else
  logic [31:0] unused_rep;

  assign unused_rep = 32'(REPEAT_CYCLES);
  assign rep_fire   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      db_q      <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= btn_n_i;
      sync2_q   <= sync1_q;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          level_q <= 1'b0;
          if (s) begin
            state_q <= PRESS_WAIT;
            db_q    <= 32'd1;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_q <= IDLE;
            db_q    <= '0;
          end else if (db_q == DB) begin
            state_q <= PRESSED;
            press_q <= 1'b1;
            level_q <= 1'b1;
            hold_q  <= '0;
            db_q    <= '0;
          end else begin
            db_q <= db_q + 32'd1;
          end
        end
        PRESSED: begin
          if (hold_q != LP) begin
            hold_q <= hold_q + 32'd1;
            long_q <= (hold_q + 32'd1 == LP);
          end
          press_q <= rep_fire;
          if (!s) begin
            state_q <= RELEASE_WAIT;
            db_q    <= 32'd1;
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state_q <= PRESSED;
            db_q    <= '0;
          end else if (db_q == DB) begin
            state_q   <= IDLE;
            release_q <= 1'b1;
            level_q   <= 1'b0;
            hold_q    <= '0;
            db_q      <= '0;
          end else begin
            db_q <= db_q + 32'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/btn_conditioner.sv
// Two-button front-end: raw active-low pins to clean one-cycle events.
// Ports: clk, reset (sync, active-low), btn_n[1:0] (raw, active-low),
//   level, press, release_p, long_press [1:0]; BTN_REPEAT_EN adds repeat.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES   = BTN_DEBOUNCE_DEF,
  parameter int unsigned LONG_PRESS_CYCLES = BTN_LONG_DEF,
  parameter int unsigned REPEAT_CYCLES     = BTN_REPEAT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn_n,
  output logic [1:0] level,
  output logic [1:0] press,
  output logic [1:0] release_p,
  output logic [1:0] long_press
);

  for (genvar i = 0; i < 2; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .btn_n_i  (btn_n[i]),
      .level_o  (level[i]),
      .press_o  (press[i]),
      .release_o(release_p[i]),
      .long_o   (long_press[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
// Randomised and directed bench for btn_conditioner.
// Reference model tracks runs of opposite samples per button.
module tb_btn_conditioner;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] btn_n = 2'b11;
  logic [1:0] level;
  logic [1:0] press;
  logic [1:0] release_p;
  logic [1:0] long_press;

  int checks = 0;
  int failures = 0;

  // model state
  bit m_d1 [2];
  bit m_d2 [2];
  bit m_lvl [2];
  int m_run [2];
  int m_hold [2];
  int m_rep [2];
  logic [1:0] e_lvl, e_prs, e_rel, e_lng;

  btn_conditioner #(
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(L),
    .REPEAT_CYCLES    (R)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_n     (btn_n),
    .level     (level),
    .press     (press),
    .release_p (release_p),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference model, driven by spec-level rules:
  // an event fires after D+1 consecutive samples opposite to the level.
  task automatic model_edge(bit rst_n, logic [1:0] pins);
    e_prs = '0;
    e_rel = '0;
    e_lng = '0;
    for (int c = 0; c < 2; c++) begin
      if (!rst_n) begin
        m_d1[c] = 1; m_d2[c] = 1; m_lvl[c] = 0;
        m_run[c] = 0; m_hold[c] = 0; m_rep[c] = 0;
      end else begin
        bit s;
        s = !m_d2[c];
        m_d2[c] = m_d1[c];
        m_d1[c] = pins[c];
        if (m_lvl[c] && m_run[c] == 0) begin
          if (m_hold[c] < L) begin
            m_hold[c]++;
            if (m_hold[c] == L) e_lng[c] = 1'b1;
          end else begin
`ifdef BTN_REPEAT_EN
            m_rep[c]++;
            if (m_rep[c] == R) begin
              e_prs[c] = 1'b1;
              m_rep[c] = 0;
            end
`endif
          end
        end
        if (s != m_lvl[c]) m_run[c]++;
        else m_run[c] = 0;
        if (m_run[c] == D + 1) begin
          m_run[c] = 0;
          m_lvl[c] = !m_lvl[c];
          m_hold[c] = 0;
          if (m_lvl[c]) e_prs[c] = 1'b1;
          else begin
            e_rel[c] = 1'b1;
            m_rep[c] = 0;
          end
        end
      end
      e_lvl[c] = m_lvl[c];
    end
  endtask

  task automatic step(bit r, logic [1:0] b);
    reset = r;
    btn_n = b;
    @(posedge clk);
    model_edge(r, b);
    #1;
    check("level", 32'(level), 32'(e_lvl));
    check("press", 32'(press), 32'(e_prs));
    check("release_p", 32'(release_p), 32'(e_rel));
    check("long_press", 32'(long_press), 32'(e_lng));
  endtask

  initial begin
    int at;
    int at2;
    int n;
    logic [1:0] b;
    int dur [2];

    // reset state
    for (int i = 0; i < 3; i++) step(0, 2'b11);
    check("rst_out", 32'({level, press, release_p, long_press}), 32'd0);
    for (int i = 0; i < 10; i++) step(1, 2'b11);

    // clean press on bit 0 with long hold
    at = -1; at2 = -1; n = 0;
    for (int i = 0; i < 52; i++) begin
      step(1, 2'b10);
      if (press[0]) begin
        n++;
        if (at < 0) at = i;
      end
      if (long_press[0] && at2 < 0) at2 = i;
      check("s1_bit1_quiet", 32'({press[1], level[1]}), 32'd0);
    end
    check("s1_press_lat", at, 6);
    check("s1_long_lat", at2, 26);
`ifdef BTN_REPEAT_EN
    check("s1_press_cnt", n, 4);
`else
    check("s1_press_cnt", n, 1);
`endif
    for (int i = 0; i < 10; i++) step(1, 2'b11);

    // bounce on bit 1
    for (int i = 0; i < 3; i++) step(1, 2'b01);
    step(1, 2'b11);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      step(1, 2'b01);
      if (press[1] && at < 0) at = i;
    end
    check("s2_press_lat", at, 6);
    for (int i = 0; i < 10; i++) step(1, 2'b11);

    // release with glitch on bit 0
    for (int i = 0; i < 12; i++) step(1, 2'b10);
    n = 0;
    for (int i = 0; i < 2; i++) begin
      step(1, 2'b11);
      n += press[0];
    end
    step(1, 2'b10);
    check("s3_lvl_glitch", 32'(level[0]), 32'd1);
    at = -1;
    for (int i = 0; i < 12; i++) begin
      step(1, 2'b11);
      n += press[0];
      if (release_p[0] && at < 0) at = i;
    end
    check("s3_rel_lat", at, 6);
    check("s3_no_repress", n, 0);

    // simultaneous press
    at = -1;
    for (int i = 0; i < 10; i++) begin
      step(1, 2'b00);
      if (press == 2'b11 && at < 0) at = i;
    end
    check("s4_both_lat", at, 6);
    for (int i = 0; i < 3; i++) step(1, 2'b10);
    for (int i = 0; i < 12; i++) step(1, 2'b11);

    // reset mid-hold
    for (int i = 0; i < 16; i++) step(1, 2'b10);
    step(0, 2'b10);
    check("s5_rst_out", 32'({level, press, long_press}), 32'd0);
    at = -1; at2 = -1;
    for (int i = 0; i < 30; i++) begin
      step(1, 2'b10);
      if (press[0] && at < 0) at = i;
      if (long_press[0] && at2 < 0) at2 = i;
    end
    check("s5_repress_lat", at, 6);
    check("s5_long_lat", at2, 26);
    for (int i = 0; i < 12; i++) step(1, 2'b11);

    // random phases with bounces and rare resets
    b = 2'b11;
    dur[0] = 0;
    dur[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (dur[c] == 0) begin
          b[c] = ~b[c];
          dur[c] = ($urandom_range(0, 3) == 0) ?
                   $urandom_range(1, 3) : $urandom_range(4, 40);
        end
        dur[c]--;
      end
      step(($urandom_range(0, 299) != 0), b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_conditioner.md
# btn_conditioner

- Input front-end for the LED game boards: turns raw active-low push-buttons into clean, single-cycle, active-high events.
- Each button is synchronised to `clk`, debounced and edge-detected. Hold time is tracked per button to produce a long-press event and, optionally, auto-repeat.
- Sits between the board button pins and the game/LED state machines, which consume `press` pulses instead of sampling raw button levels.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a level change (20 ms at 50 MHz); must be ≥ 1.
- `LONG_PRESS_CYCLES`, 50_000_000: hold cycles after accepted press before `long_press`; must be > `DEBOUNCE_CYCLES`.
- `REPEAT_CYCLES`, 12_500_000: auto-repeat period (used only with `BTN_REPEAT_EN`); must be ≥ 1.
- `clk`  input  1  system clock.
- `reset`  input  1  synchronous, active-low reset.
- `btn_n`  input  2  raw button pins, active-low, asynchronous to `clk`; bit 0 = btn1, bit 1 = btn2.
- `level`  output  2  debounced state, 1 = pressed.
- `press`  output  2  one-cycle pulse per accepted press (plus repeats when enabled).
- `release_p`  output  2  one-cycle pulse per accepted release.
- `long_press`  output  2  one-cycle pulse, once per hold, when hold reaches `LONG_PRESS_CYCLES`.

## Operation
- Reset: `clk` is the clock; `reset` is synchronous, active-low. Every output is held at 0 and every channel is held in `IDLE`, counters 0.
- Synchroniser: 2-FF per bit, reset value 1 (released). The synchronised sample `s` is taken as `~sync2`, so `s` = 1 means pressed.
- Per-channel state machine, identical and fully independent for both bits:
  - `IDLE`: `level` = 0. `s` = 1 → `PRESS_WAIT`, debounce counter = 1.
  - `PRESS_WAIT`:
    - `s` = 0 → back to `IDLE`, counter cleared; this is a bounce and no event is emitted.
    - Counter reaches `DEBOUNCE_CYCLES` → `PRESSED`, `press` = 1 for that cycle, `level` = 1, hold counter = 0.
    - Otherwise, counter +1.
  - `PRESSED`:
    - Hold counter +1 per cycle, saturating at `LONG_PRESS_CYCLES`.
    - On the cycle it reaches `LONG_PRESS_CYCLES`: `long_press` = 1.
    - `s` = 0 → `RELEASE_WAIT`, debounce counter = 1.
  - `RELEASE_WAIT`:
    - `level` stays 1; hold counter frozen.
    - `s` = 1 → back to `PRESSED` with hold counter preserved; no event.
    - Counter reaches `DEBOUNCE_CYCLES` → `IDLE`, `release_p` = 1, `level` = 0, hold counter cleared.
- Counters: 32-bit unsigned, compared with `==`. They can never exceed their parameter, so they never wrap.
- Simultaneous events on both bits are independent; both pulses may assert in the same cycle.
- A `long_press` is never emitted without a preceding `press` in the same hold.

## Timing
- `press` latency: a clean pin edge at cycle 0 gives `press` at cycle `DEBOUNCE_CYCLES` + 2 (2 synchroniser cycles + debounce).
- `release_p` latency: identical to `press` latency.
- `long_press`: exactly `LONG_PRESS_CYCLES` cycles after the `press` pulse, provided no release was accepted in between.
- Bounce: any opposite sample during a wait state restarts debouncing. The event fires `DEBOUNCE_CYCLES` cycles after the last bounce sample.
- All outputs are registered; pulses are exactly 1 cycle wide.
- Reset mid-operation: outputs are 0 on the first cycle after `reset` is sampled low, and pending counts are discarded.
- If a button is held through reset, `press` fires `DEBOUNCE_CYCLES` + 2 cycles after `reset` deasserts.

## Configuration
- `BTN_REPEAT_EN` defined (auto-repeat enabled):
  - In `PRESSED`, after `long_press`, a repeat counter emits an additional `press` pulse every `REPEAT_CYCLES` cycles while held.
  - The repeat counter is frozen in `RELEASE_WAIT` and cleared on accepted release.
- `BTN_REPEAT_EN` undefined: no repeat counter is synthesised, `REPEAT_CYCLES` is ignored, and exactly one `press` pulse is emitted per hold.

## Structure
- Package `btn_pkg`:
  - `typedef enum {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} e_btn_state`.
  - Default cycle constants `BTN_DEBOUNCE_DEF`, `BTN_LONG_DEF`, `BTN_REPEAT_DEF`.
- Sub-module `btn_channel` contains the synchroniser, state machine and counters for one button.
- `btn_conditioner` instantiates `btn_channel` twice via generate and passes the parameters through.

## Test plan
Bench parameters for all scenarios: `DEBOUNCE_CYCLES` = 4, `LONG_PRESS_CYCLES` = 20, `REPEAT_CYCLES` = 8.
- Clean press: `btn_n[0]` 1→0 at cycle 10 and held → `press[0]` at cycle 16 only, `level[0]` = 1 from cycle 16, `long_press[0]` at cycle 36; bit 1 stays 0.
- Bounce: `btn_n[1]` low for 3 cycles, high 1, low and held → no event during the bounce; `press[1]` 6 cycles after the final falling edge.
- Release with glitch: held, then `btn_n[0]` high 2 cycles, low 1, high and held → `level[0]` stays 1 through the glitch; `release_p[0]` 6 cycles after the final rising edge; no second `press`.
- Simultaneous: both bits fall in the same cycle → `press` = 2'b11 in a single cycle; later releases are reported independently.
- Reset mid-hold: `reset` low for 1 cycle at hold cycle 10 while the button is held → outputs 0 next cycle; `press` re-fires 6 cycles after `reset` returns high; no `long_press` before 20 further cycles.
- With `BTN_REPEAT_EN`: hold 50 cycles after `press` → `long_press` at +20, then extra `press` pulses at +28, +36, +44; without the macro, no extra pulses.
